// File: rtl/pipe_fetch_queue_if.sv
// Fetch front-end bundle: instruction memory request channel plus the
// queue-head / decoder feedback channel of the ID stage.
interface pipe_fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc4;
    logic        nostall;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] jpc;
    logic [31:0] ra;

    modport master (
        output imem_req, imem_addr, id_valid, id_inst, id_pc4,
        input  imem_ack, imem_rdata, nostall, pcsource, bpc, jpc, ra
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_inst, id_pc4,
        output imem_ack, imem_rdata, nostall, pcsource, bpc, jpc, ra
    );
endinterface

// File: rtl/pipe_fetch_queue.sv
// Instruction fetch queue: one outstanding imem request, DEPTH-entry
// buffer, delay-slot preserving redirects driven by the ID stage.
module pipe_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                clk,
    input logic                rst,
    pipe_fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;
    typedef enum logic [1:0] {IDLE, WAIT, WAIT_DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        pend_q, pend_d;
    ptr_t        rd_q, rd_d;
    ptr_t        wr_q, wr_d;
    cnt_t        cnt_q, cnt_d;
    logic [31:0] inst_q [DEPTH];
    logic [31:0] pc4_q  [DEPTH];

    logic        busy, acc, pop, rdir, push, drop;
    logic        keep_slot, keep_req, pend_e;
    logic [31:0] hd_pc4, sel_tgt, fpc_e, tgt_e;

    always_comb begin
        busy      = (state_q != IDLE);
        acc       = busy & bus.imem_ack;
        pop       = (cnt_q != '0) & bus.nostall;
        rdir      = pop & (bus.pcsource != 2'b00);
        hd_pc4    = pc4_q[rd_q];
        keep_slot = (cnt_q > cnt_t'(1));
        keep_req  = (state_q == WAIT) && (addr_q == hd_pc4);
        unique case (bus.pcsource)
            2'b10:   sel_tgt = bus.ra;
            2'b11:   sel_tgt = bus.jpc;
            default: sel_tgt = bus.bpc;
        endcase

        push   = acc & (state_q == WAIT);
        drop   = 1'b0;
        fpc_e  = fpc_q;
        tgt_e  = tgt_q;
        pend_e = pend_q;
        if (rdir) begin
            pend_e = 1'b0;
            if (keep_slot) begin
                fpc_e = sel_tgt;
                push  = 1'b0;
                drop  = 1'b1;
            end else if (keep_req) begin
                fpc_e = sel_tgt;
            end else begin
                // delay slot not fetched yet: fetch it, then the target
                fpc_e  = hd_pc4;
                tgt_e  = sel_tgt;
                pend_e = 1'b1;
                push   = 1'b0;
                drop   = 1'b1;
            end
        end

        rd_d  = rd_q + ptr_t'(pop);
        wr_d  = wr_q + ptr_t'(push);
        cnt_d = cnt_q + cnt_t'(push) - cnt_t'(pop);
        if (rdir && keep_slot) begin
            rd_d  = rd_q + ptr_t'(1);
            wr_d  = rd_q + ptr_t'(2);
            cnt_d = cnt_t'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        fpc_d   = fpc_e;
        tgt_d   = tgt_e;
        pend_d  = pend_e;
        if (acc) begin
            state_d = IDLE;
        end else if (drop && busy) begin
            state_d = WAIT_DROP;
        end
        if (state_d == IDLE && cnt_d < cnt_t'(DEPTH)) begin
            state_d = WAIT;
            addr_d  = fpc_e;
            if (pend_e) begin
                fpc_d  = tgt_e;
                pend_d = 1'b0;
            end else begin
                fpc_d = fpc_e + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= RESET_PC;
            fpc_q   <= RESET_PC;
            tgt_q   <= '0;
            pend_q  <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            fpc_q   <= fpc_d;
            tgt_q   <= tgt_d;
            pend_q  <= pend_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[wr_q] <= bus.imem_rdata;
            pc4_q[wr_q]  <= addr_q + 32'd4;
        end
    end

    assign bus.imem_req  = busy;
    assign bus.imem_addr = addr_q;
    assign bus.id_valid  = (cnt_q != '0);
    assign bus.id_inst   = bus.id_valid ? inst_q[rd_q] : 32'd0;
    assign bus.id_pc4    = bus.id_valid ? pc4_q[rd_q] : 32'd0;
endmodule

// File: tb/tb_pipe_fetch_queue.sv
// Bench for pipe_fetch_queue: memory model, decoder driver and a
// scoreboard monitor checking the delivered instruction stream.
module tb_pipe_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h100;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_fetch_queue_if bus ();

    pipe_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] acc_log[$];
    int          budget = 0;
    int          lat = 1;
    int          wcnt = 0;
    int          acks = 0;
    bit          hold = 1'b0;
    bit          force_ack = 1'b0;
    logic [31:0] br_pc4 [2];
    logic [1:0]  br_src [2];
    int          br_stall [2];

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Memory: ack after lat cycles of a held request
    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (force_ack) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = 32'hBAD0_BAD0;
                wcnt = 0;
            end else if (!bus.imem_req) begin
                bus.imem_ack = 1'b0;
                wcnt = 0;
            end else begin
                bus.imem_ack = (wcnt >= lat - 1);
                if (bus.imem_ack) begin
                    wcnt = 0;
                    acks++;
                    acc_log.push_back(bus.imem_addr);
                    bus.imem_rdata = word(bus.imem_addr);
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Decoder: consume while budget lasts, redirect on table hits
    initial begin
        bus.nostall  = 1'b0;
        bus.pcsource = 2'b00;
        forever begin
            @(negedge clk);
            bus.nostall  = 1'b0;
            bus.pcsource = 2'b00;
            if (!hold && budget > 0) begin
                bus.nostall = 1'b1;
                for (int i = 0; i < 2; i++) begin
                    if (bus.id_valid && br_pc4[i] != 32'd0 &&
                        bus.id_pc4 == br_pc4[i]) begin
                        if (br_stall[i] > 0) begin
                            bus.nostall = 1'b0;
                            br_stall[i]--;
                        end else begin
                            bus.pcsource = br_src[i];
                        end
                    end
                end
            end
        end
    end

    // Monitor: every consumed head is checked against the scoreboard
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.id_valid && bus.nostall) begin
                budget--;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL extra_pop: got pc4 %h expected none",
                             bus.id_pc4);
                end else begin
                    e = exp_q.pop_front();
                    chk("pc4", bus.id_pc4, e);
                    chk("inst", bus.id_inst, word(e - 32'd4));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic do_reset(input bit hold_v);
        rst = 1'b1;
        hold = hold_v;
        budget = 0;
        for (int i = 0; i < 2; i++) begin
            br_pc4[i] = 32'd0;
            br_src[i] = 2'b00;
            br_stall[i] = 0;
        end
        exp_q.delete();
        repeat (3) @(posedge clk);
        acks = 0;
        acc_log.delete();
        #1;
    endtask

    task automatic wait_done(input int maxc);
        int c = 0;
        while (exp_q.size() != 0 && c < maxc) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bus.bpc = 32'd0;
        bus.jpc = 32'd0;
        bus.ra  = 32'd0;

        // reset state
        do_reset(1'b0);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_addr", bus.imem_addr, RPC);
        chk("rst_valid", 32'(bus.id_valid), 32'd0);
        chk("rst_inst", bus.id_inst, 32'd0);
        chk("rst_pc4", bus.id_pc4, 32'd0);

        // streaming at one instruction per cycle
        for (int i = 1; i <= 6; i++) exp_q.push_back(RPC + 32'(4 * i));
        budget = 6;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("first_req", 32'(bus.imem_req), 32'd1);
        chk("first_addr", bus.imem_addr, RPC);
        repeat (7) @(posedge clk);
        #1;
        chk("stream_rate", 32'(exp_q.size()), 32'd0);
        chk("stream_head", bus.id_pc4, 32'h11C);

        // backpressure fills exactly DEPTH entries
        do_reset(1'b1);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("bp_req", 32'(bus.imem_req), 32'd0);
        chk("bp_acks", 32'(acks), 32'(DEPTH));
        chk("bp_head", bus.id_pc4, RPC + 32'd4);
        for (int i = 1; i <= 6; i++) exp_q.push_back(RPC + 32'(4 * i));
        budget = 6;
        hold = 1'b0;
        wait_done(40);

        // taken branch at 0x200, slot queued, latency 3
        do_reset(1'b0);
        lat = 3;
        bus.bpc = 32'h400;
        br_pc4[0] = 32'h204;
        br_src[0] = 2'b01;
        br_stall[0] = 6;
        for (int a = 'h100; a <= 'h204; a += 4) exp_q.push_back(32'(a + 4));
        exp_q.push_back(32'h404);
        exp_q.push_back(32'h408);
        budget = exp_q.size();
        rst = 1'b0;
        wait_done(800);

        // branch to 0x300, then jump at 0x300 with empty queue
        do_reset(1'b0);
        lat = 1;
        bus.bpc = 32'h300;
        bus.jpc = 32'h800;
        br_pc4[0] = 32'h104;
        br_src[0] = 2'b01;
        br_pc4[1] = 32'h304;
        br_src[1] = 2'b11;
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        exp_q.push_back(32'h304);
        exp_q.push_back(32'h308);
        exp_q.push_back(32'h804);
        exp_q.push_back(32'h808);
        budget = 6;
        rst = 1'b0;
        wait_done(60);
        chk("j_req2", acc_log[2], 32'h300);
        chk("j_req3", acc_log[3], 32'h304);
        chk("j_req4", acc_log[4], 32'h800);

        // jr in the slot, same-edge ack for 0x300 is dropped
        do_reset(1'b0);
        bus.bpc = 32'h300;
        bus.ra  = 32'h1000;
        br_pc4[0] = 32'h104;
        br_src[0] = 2'b01;
        br_pc4[1] = 32'h108;
        br_src[1] = 2'b10;
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        exp_q.push_back(32'h10C);
        exp_q.push_back(32'h1004);
        exp_q.push_back(32'h1008);
        budget = 5;
        rst = 1'b0;
        wait_done(60);
        chk("jr_req2", acc_log[2], 32'h300);
        chk("jr_req3", acc_log[3], 32'h108);
        chk("jr_req4", acc_log[4], 32'h1000);

        // reset with a request outstanding, then a stray ack
        do_reset(1'b0);
        lat = 5;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_req", 32'(bus.imem_req), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        force_ack = 1'b1;
        chk("mid_rst_req", 32'(bus.imem_req), 32'd0);
        chk("mid_rst_valid", 32'(bus.id_valid), 32'd0);
        chk("mid_rst_addr", bus.imem_addr, RPC);
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        lat = 1;
        chk("late_ack_valid", 32'(bus.id_valid), 32'd0);
        chk("late_ack_req", 32'(bus.imem_req), 32'd1);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        budget = 2;
        wait_done(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
